// File: rtl/read_buffer.sv
// Read-return buffer: captures burst data from the RAMs, presents it first-word-fall-through,
// and hands the controller credits so a read is issued only when its whole burst has room.
module read_buffer #(
    parameter int DEPTH_LOG2 = 7,
    parameter int BURST      = 2
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  ReadReq,
    output logic                  CanRead,
    input  logic [127:0]          MD,
    input  logic                  MDvalid,
    output logic [127:0]          RD,
    output logic                  Empty,
    input  logic                  RDen,
    output logic [DEPTH_LOG2:0]   Count,
    output logic                  Err
);

    localparam int PW    = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [PW:0] DEPTH_W = (PW + 1)'(DEPTH);
    localparam logic [PW:0] BURST_W = (PW + 1)'(BURST);

    logic [127:0]  mem [DEPTH];

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW-1:0] outst_q, outst_d;
    logic          can_read_q, can_read_d;
    logic          empty_q, empty_d;
    logic          err_q, err_d;
    logic [127:0]  rd_q, rd_d;

    logic          accept;
    logic          wr_en;
    logic          pop;
    logic [PW:0]   used_d;

    always_comb begin
        accept     = ReadReq & can_read_q;
        wr_en      = MDvalid & (outst_q != '0);
        pop        = RDen & ~empty_q;

        wptr_d     = wptr_q + PW'(wr_en);
        rptr_d     = rptr_q + PW'(pop);
        outst_d    = outst_q + (accept ? PW'(BURST) : '0) - PW'(wr_en);

        // Credits come from next-state values so a freshly reserved burst is never double-counted.
        used_d     = {1'b0, wptr_d - rptr_d} + {1'b0, outst_d};
        can_read_d = (DEPTH_W - used_d) >= BURST_W;

        // Head register loads from words written before this edge, giving one cycle of fall-through.
        empty_d    = (rptr_d == wptr_q);
        rd_d       = empty_d ? rd_q : mem[rptr_d[DEPTH_LOG2-1:0]];

        err_d      = err_q | (ReadReq & ~can_read_q) | (MDvalid & (outst_q == '0));
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            outst_q    <= '0;
            can_read_q <= 1'b1;
            empty_q    <= 1'b1;
            err_q      <= 1'b0;
            rd_q       <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            outst_q    <= outst_d;
            can_read_q <= can_read_d;
            empty_q    <= empty_d;
            err_q      <= err_d;
            rd_q       <= rd_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (wr_en && !Reset) begin
            mem[wptr_q[DEPTH_LOG2-1:0]] <= MD;
        end
    end

    assign CanRead = can_read_q;
    assign Empty   = empty_q;
    assign RD      = rd_q;
    assign Count   = wptr_q - rptr_q;
    assign Err     = err_q;

endmodule

// File: tb/tb_read_buffer.sv
// Directed bench for read_buffer: a reference queue holds returned words until the user pops them.
module tb_read_buffer;

    localparam int DL    = 7;
    localparam int DEPTH = 128;
    localparam int B     = 2;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          ReadReq = 1'b0;
    logic          CanRead;
    logic [127:0]  MD = '0;
    logic          MDvalid = 1'b0;
    logic [127:0]  RD;
    logic          Empty;
    logic          RDen = 1'b0;
    logic [DL:0]   Count;
    logic          Err;

    read_buffer #(.DEPTH_LOG2(DL), .BURST(B)) dut (
        .Clk(Clk), .Reset(Reset), .ReadReq(ReadReq), .CanRead(CanRead),
        .MD(MD), .MDvalid(MDvalid), .RD(RD), .Empty(Empty), .RDen(RDen),
        .Count(Count), .Err(Err)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    logic [127:0] q[$];
    int           m_o = 0;
    logic         m_can = 1'b1;
    logic         m_empty = 1'b1;
    logic         m_err = 1'b0;

    localparam logic [127:0] A0 = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_00A0;
    localparam logic [127:0] A1 = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_00A1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the reference model across the edge, compare on the falling edge.
    task automatic cycle(input logic rst, input logic rr, input logic mdv,
                         input logic [127:0] md, input logic rden);
        logic acc, wr, pop, empty_next;
        Reset = rst; ReadReq = rr; MDvalid = mdv; MD = md; RDen = rden;
        @(posedge Clk);
        if (rst) begin
            q.delete();
            m_o = 0; m_can = 1'b1; m_empty = 1'b1; m_err = 1'b0;
        end else begin
            acc  = rr & m_can;
            wr   = mdv & (m_o > 0);
            pop  = rden & ~m_empty;
            m_err = m_err | (rr & ~m_can) | (mdv & (m_o == 0));
            empty_next = ((q.size() - int'(pop)) == 0);
            if (pop) void'(q.pop_front());
            if (wr) q.push_back(md);
            m_o = m_o + (acc ? B : 0) - int'(wr);
            m_can = ((DEPTH - q.size() - m_o) >= B);
            m_empty = empty_next;
        end
        @(negedge Clk);
        Reset = 1'b0; ReadReq = 1'b0; MDvalid = 1'b0; RDen = 1'b0;
        chk("empty", 128'(Empty), 128'(m_empty));
        chk("count", 128'(Count), 128'(q.size()));
        chk("canread", 128'(CanRead), 128'(m_can));
        chk("err", 128'(Err), 128'(m_err));
        if (!m_empty) chk("rd", RD, q[0]);
    endtask

    initial begin
        logic [127:0] nxt;
        logic         rr_s, md_s;

        // Reset state
        cycle(1, 0, 0, '0, 0);
        cycle(1, 0, 0, '0, 0);
        chk("rst_rd", RD, 128'h0);
        chk("rst_empty", 128'(Empty), 128'd1);
        chk("rst_canread", 128'(CanRead), 128'd1);
        chk("rst_count", 128'(Count), 128'd0);

        // Single burst, user popping continuously
        cycle(0, 1, 0, '0, 0);
        cycle(0, 0, 1, A0, 1);
        chk("ff_empty_t", 128'(Empty), 128'd1);
        cycle(0, 0, 1, A1, 1);
        chk("ff_empty_t1", 128'(Empty), 128'd0);
        chk("ff_rd_a0", RD, A0);
        cycle(0, 0, 0, '0, 1);
        chk("ff_rd_a1", RD, A1);
        cycle(0, 0, 0, '0, 1);
        chk("ff_count0", 128'(Count), 128'd0);
        chk("ff_err0", 128'(Err), 128'd0);

        // Credit exhaustion: 64 bursts reserve all 128 entries
        cycle(1, 0, 0, '0, 0);
        for (int i = 0; i < 64; i++) cycle(0, 1, 0, '0, 0);
        chk("credit_canread0", 128'(CanRead), 128'd0);
        cycle(0, 1, 0, '0, 0);
        chk("credit_err", 128'(Err), 128'd1);
        cycle(0, 0, 1, 128'h100, 0);
        cycle(0, 0, 1, 128'h101, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, '0, 1);
        chk("credit_canread1", 128'(CanRead), 128'd1);

        // Full storage, then an unrequested word is dropped
        cycle(1, 0, 0, '0, 0);
        for (int i = 0; i < 64; i++) cycle(0, 1, 0, '0, 0);
        for (int i = 0; i < 128; i++) cycle(0, 0, 1, 128'h5500 + 128'(i), 0);
        chk("full_count", 128'(Count), 128'd128);
        chk("full_err0", 128'(Err), 128'd0);
        cycle(0, 0, 1, 128'hBAD, 0);
        chk("drop_count", 128'(Count), 128'd128);
        chk("drop_err", 128'(Err), 128'd1);
        for (int i = 0; i < 130; i++) cycle(0, 0, 0, '0, 1);
        chk("drain_count", 128'(Count), 128'd0);
        chk("drain_empty", 128'(Empty), 128'd1);

        // Streaming across several pointer wraps
        cycle(1, 0, 0, '0, 0);
        nxt = 128'h1000;
        for (int i = 0; i < 1000; i++) begin
            rr_s = m_can;
            md_s = (m_o > 0);
            cycle(0, rr_s, md_s, nxt, (i < 500) ? 1'b1 : ($urandom_range(0, 3) != 0));
            if (md_s) nxt = nxt + 128'd1;
            chk("stream_count_le", 128'(Count <= 8'd128), 128'd1);
        end
        for (int i = 0; i < 300; i++) cycle(0, 0, (m_o > 0), nxt + 128'(i), 1);
        chk("stream_err0", 128'(Err), 128'd0);

        // Accept and return in the same cycle with one word outstanding
        cycle(1, 0, 0, '0, 0);
        cycle(0, 1, 0, '0, 0);
        cycle(0, 0, 1, 128'h77, 0);
        cycle(0, 1, 1, 128'h78, 0);
        chk("same_count", 128'(Count), 128'd2);
        chk("same_canread", 128'(CanRead), 128'd1);
        cycle(0, 0, 1, 128'h79, 0);
        cycle(0, 0, 1, 128'h7A, 0);
        chk("same_count4", 128'(Count), 128'd4);
        chk("same_err0", 128'(Err), 128'd0);

        // Reset mid-burst with five stored and three outstanding
        cycle(1, 0, 0, '0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, '0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 1, 128'h900 + 128'(i), 0);
        chk("mid_count5", 128'(Count), 128'd5);
        cycle(1, 0, 1, 128'h999, 0);
        chk("mid_empty", 128'(Empty), 128'd1);
        chk("mid_count0", 128'(Count), 128'd0);
        chk("mid_canread", 128'(CanRead), 128'd1);
        chk("mid_err0", 128'(Err), 128'd0);
        cycle(0, 0, 1, 128'h99A, 0);
        chk("late_err", 128'(Err), 128'd1);
        chk("late_count", 128'(Count), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
